// File: rtl/rtc_reg_seq.sv
// RTC register-access sequencer: walks a burst of consecutive registers, driving address then RD/WR strobes.
// Optional feature: define RTC_SEQ_ABORT_EN to add an abort input that cuts a burst short.
`timescale 1ns/1ps

module rtc_reg_seq #(
  parameter int ADDR_W    = 8,
  parameter int MAX_REGS  = 8,
  parameter int ADDR_MIN  = 5,
  parameter int ADDR_MAX  = 7,
  parameter int DEF_ADDR  = 5,
  parameter int SETUP_CYC = 2,
  parameter int RD_CYC    = 257,
  parameter int WR_CYC    = 256,
  parameter int GAP_CYC   = 4,
  localparam int CNT_W    = $clog2(MAX_REGS + 1)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef RTC_SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] dir_out,
  output logic              RD,
  output logic              WR,
  output logic              busy,
  output logic              ready,
  output logic              err
);

  localparam int MAX_AB  = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int MAX_CD  = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);

  localparam logic [ADDR_W-1:0] A_MIN = ADDR_W'(ADDR_MIN);
  localparam logic [ADDR_W-1:0] A_MAX = ADDR_W'(ADDR_MAX);
  localparam logic [ADDR_W-1:0] A_DEF = ADDR_W'(DEF_ADDR);

  typedef enum logic [2:0] {IDLE, SETUP, RD_PH, WR_PH, GAP, DONE} state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              do_rd_q, do_rd_d;
  logic              do_wr_q, do_wr_d;
  logic [ADDR_W-1:0] dir_q, dir_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] addr_base;
  logic [CNT_W-1:0]  addr_idx;
  logic [ADDR_W-1:0] raw_addr;
  logic              addr_bad;
  logic [CNT_W-1:0]  cnt_clamped;
  logic              reg_end;
  logic              abort_hit;

`ifdef RTC_SEQ_ABORT_EN
  assign abort_hit = abort && (state_q == SETUP || state_q == RD_PH ||
                               state_q == WR_PH || state_q == GAP);
`else
  assign abort_hit = 1'b0;
`endif

  // Address for the register about to enter SETUP: first one from IDLE, next one from GAP.
  always_comb begin
    addr_base = (state_q == IDLE) ? base_addr : base_q;
    addr_idx  = (state_q == GAP) ? idx_q + CNT_W'(1) : '0;
    raw_addr  = addr_base + ADDR_W'(addr_idx);
    addr_bad  = (raw_addr < A_MIN) || (raw_addr > A_MAX);
    if (count == '0)
      cnt_clamped = CNT_W'(1);
    else if (count > CNT_W'(MAX_REGS))
      cnt_clamped = CNT_W'(MAX_REGS);
    else
      cnt_clamped = count;
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    do_rd_d = do_rd_q;
    do_wr_d = do_wr_q;
    dir_d   = dir_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    err_d   = err_q;
    reg_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          cnt_d   = cnt_clamped;
          do_rd_d = (mode != 2'b10);
          do_wr_d = (mode != 2'b01);
          idx_d   = '0;
          err_d   = addr_bad;
          dir_d   = addr_bad ? A_DEF : raw_addr;
          busy_d  = 1'b1;
          cyc_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cyc_q == CYC_W'(SETUP_CYC - 1)) begin
          cyc_d = '0;
          if (do_rd_q) begin
            rd_d    = 1'b1;
            state_d = RD_PH;
          end else begin
            wr_d    = 1'b1;
            state_d = WR_PH;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      RD_PH: begin
        if (cyc_q == CYC_W'(RD_CYC - 1)) begin
          rd_d  = 1'b0;
          cyc_d = '0;
          if (do_wr_q) begin
            wr_d    = 1'b1;
            state_d = WR_PH;
          end else begin
            reg_end = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      WR_PH: begin
        if (cyc_q == CYC_W'(WR_CYC - 1)) begin
          wr_d    = 1'b0;
          cyc_d   = '0;
          reg_end = 1'b1;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      GAP: begin
        if (cyc_q == CYC_W'(GAP_CYC - 1)) begin
          cyc_d   = '0;
          idx_d   = idx_q + CNT_W'(1);
          err_d   = err_q | addr_bad;
          dir_d   = addr_bad ? A_DEF : raw_addr;
          state_d = SETUP;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      DONE: begin
        if (!start) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Last strobe of a register finished: move on to the next one or wrap up the burst.
    if (reg_end) begin
      if ((idx_q + CNT_W'(1)) < cnt_q) begin
        state_d = GAP;
      end else begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = DONE;
      end
    end

    if (abort_hit) begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      err_d   = 1'b1;
      cyc_d   = '0;
      busy_d  = 1'b0;
      ready_d = 1'b1;
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      do_rd_q <= 1'b0;
      do_wr_q <= 1'b0;
      dir_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      do_rd_q <= do_rd_d;
      do_wr_q <= do_wr_d;
      dir_q   <= dir_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign dir_out = dir_q;
  assign RD      = rd_q;
  assign WR      = wr_q;
  assign busy    = busy_q;
  assign ready   = ready_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rtc_reg_seq.sv
// Scoreboard bench for rtc_reg_seq: a burst-level model queues expected strobe/done events, a monitor pops them.
// Exercises the abort input only when RTC_SEQ_ABORT_EN is defined.
`timescale 1ns/1ps

module tb_rtc_reg_seq;

  localparam int T_SETUP = 2;
  localparam int T_RD    = 257;
  localparam int T_WR    = 256;
  localparam int T_GAP   = 4;
  localparam int A_MIN   = 5;
  localparam int A_MAX   = 7;
  localparam int A_DEF   = 5;
  localparam int MAXR    = 8;
  localparam int K_RD    = 0;
  localparam int K_WR    = 1;
  localparam int K_DONE  = 2;
  localparam int BOUND   = 10000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] base_addr = 8'd0;
  logic [3:0] count = 4'd0;
`ifdef RTC_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [7:0] dir_out;
  logic       RD, WR, busy, ready, err;

  typedef struct {
    int kind;
    int addr;
    int width;
    int lead;
    int err;
  } ev_t;

  ev_t expq[$];
  int  vectors = 0;
  int  miscompares = 0;

  rtc_reg_seq dut (
    .clk       (clk),
    .reset     (reset),
`ifdef RTC_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .count     (count),
    .dir_out   (dir_out),
    .RD        (RD),
    .WR        (WR),
    .busy      (busy),
    .ready     (ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic pushEvent(input int kind, input int addr, input int width, input int lead, input int e);
    ev_t ev;
    ev.kind  = kind;
    ev.addr  = addr;
    ev.width = width;
    ev.lead  = lead;
    ev.err   = e;
    expq.push_back(ev);
  endtask

  // Reference model: expands one burst request into the strobe and completion events it must produce.
  task automatic modelBurst(input int m, input int b, input int c);
    int n, a, e, lead;
    n = (c == 0) ? 1 : ((c > MAXR) ? MAXR : c);
    a = 0;
    e = 0;
    for (int i = 0; i < n; i++) begin
      a = (b + i) % 256;
      if (a < A_MIN || a > A_MAX) begin
        a = A_DEF;
        e = 1;
      end
      lead = (i == 0) ? T_SETUP : T_GAP + T_SETUP;
      if (m != 2) begin
        pushEvent(K_RD, a, T_RD, lead, 0);
        lead = 0;
      end
      if (m != 1) pushEvent(K_WR, a, T_WR, lead, 0);
    end
    pushEvent(K_DONE, a, 0, 0, e);
  endtask

  task automatic scoreboardPop(input int kind, input int addr, input int width, input int lead, input int e);
    ev_t ev;
    if (expq.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL sb_underflow: got event kind %0d addr %0d, expected no event", kind, addr);
    end else begin
      ev = expq.pop_front();
      checkOutput("ev_kind", kind, ev.kind);
      checkOutput($sformatf("ev%0d_addr", ev.kind), addr, ev.addr);
      if (ev.kind == K_DONE) begin
        checkOutput("done_err", e, ev.err);
      end else begin
        checkOutput($sformatf("ev%0d_width", ev.kind), width, ev.width);
        checkOutput($sformatf("ev%0d_lead", ev.kind), lead, ev.lead);
      end
    end
  endtask

  // Monitor: measures strobe widths, idle lead-in and completion status on every falling edge.
  int  idle, rd_w, wr_w, rd_lead, wr_lead, rd_addr, wr_addr;
  bit  prev_rd, prev_wr, prev_ready;

  initial begin
    idle = 0; rd_w = 0; wr_w = 0; rd_lead = 0; wr_lead = 0; rd_addr = 0; wr_addr = 0;
    prev_rd = 0; prev_wr = 0; prev_ready = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_rd = 0; prev_wr = 0; prev_ready = 0;
        idle = 0; rd_w = 0; wr_w = 0;
      end else begin
        checkOutput("rd_wr_excl", {31'd0, RD & WR}, 0);
        if (prev_rd && !RD) scoreboardPop(K_RD, rd_addr, rd_w, rd_lead, 0);
        if (prev_wr && !WR) scoreboardPop(K_WR, wr_addr, wr_w, wr_lead, 0);
        if (!prev_rd && RD) begin
          rd_lead = idle; rd_addr = dir_out; rd_w = 0;
        end
        if (!prev_wr && WR) begin
          wr_lead = idle; wr_addr = dir_out; wr_w = 0;
        end
        if (RD) rd_w++;
        if (WR) wr_w++;
        if (!prev_ready && ready) begin
          checkOutput("done_busy", busy, 0);
          scoreboardPop(K_DONE, dir_out, 0, 0, err);
        end
        if (RD || WR || !busy) idle = 0;
        else idle++;
        prev_rd = RD; prev_wr = WR; prev_ready = ready;
      end
    end
  end

  task automatic recoverReset();
    expq.delete();
    start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic applyStimulus(input int m, input int b, input int c, input bit drop_early);
    bit got;
    modelBurst(m, b, c);
    @(negedge clk);
    mode = 2'(m); base_addr = 8'(b); count = 4'(c); start = 1'b1;
    @(negedge clk);
    checkOutput("busy_after_start", busy, 1);
    mode = 2'($urandom); base_addr = 8'($urandom); count = 4'($urandom);
    got = 0;
    for (int i = 0; i < BOUND; i++) begin
      if (drop_early && i == 5) start = 1'b0;
      if (ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: got no ready, expected ready within %0d cycles", BOUND);
      recoverReset();
      return;
    end
    checkOutput("ready_busy_low", busy, 0);
    if (!drop_early) begin
      repeat (2) begin
        @(negedge clk);
        checkOutput("ready_held", ready, 1);
      end
      start = 1'b0;
    end
    @(negedge clk);
    checkOutput("ready_release", ready, 0);
    @(negedge clk);
    checkOutput("sb_drained", expq.size(), 0);
  endtask

  initial begin
    bit got;
    reset = 1'b0;
    #1;
    checkOutput("rst_dir", dir_out, 0);
    checkOutput("rst_rd", RD, 0);
    checkOutput("rst_wr", WR, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_err", err, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    applyStimulus(0, 6, 1, 0);
    applyStimulus(1, 3, 1, 0);
    applyStimulus(2, 5, 3, 0);
    applyStimulus(0, 6, 0, 0);
    applyStimulus(2, 254, 12, 0);
    applyStimulus(1, 7, 2, 1);
    applyStimulus(3, 4, 2, 0);

    // Reset in the middle of a read strobe, then a clean restart.
    @(negedge clk);
    mode = 2'b00; base_addr = 8'd6; count = 4'd1; start = 1'b1;
    got = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (RD) begin
        got = 1;
        break;
      end
    end
    checkOutput("rst_rd_seen", got, 1);
    repeat (99) @(negedge clk);
    #2 reset = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("midrst_rd", RD, 0);
    checkOutput("midrst_wr", WR, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", ready, 0);
    checkOutput("midrst_err", err, 0);
    checkOutput("midrst_dir", dir_out, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    applyStimulus(0, 6, 1, 0);

`ifdef RTC_SEQ_ABORT_EN
    pushEvent(K_WR, 5, 10, T_SETUP, 0);
    pushEvent(K_DONE, 5, 0, 0, 1);
    @(negedge clk);
    mode = 2'b10; base_addr = 8'd5; count = 4'd1; start = 1'b1;
    got = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (WR) begin
        got = 1;
        break;
      end
    end
    checkOutput("abort_wr_seen", got, 1);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_wr", WR, 0);
    checkOutput("abort_err", err, 1);
    checkOutput("abort_ready", ready, 1);
    start = 1'b0;
    @(negedge clk);
    checkOutput("abort_release", ready, 0);
    @(negedge clk);
    checkOutput("abort_drained", expq.size(), 0);
`endif

    for (int r = 0; r < 8; r++) begin
      int m, b, c;
      m = $urandom_range(0, 3);
      b = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 10) : $urandom_range(250, 255);
      c = $urandom_range(0, 15);
      applyStimulus(m, b, c, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
